// File: rtl/axil_wr_cmd_master.sv
// Flat write-command stream to AXI4-lite write master with bounded outstanding writes.
// Each accepted command becomes one AW/W pair; every BRESP is forwarded in command order.
//  state | meaning
//  IDLE  | no AW/W beat pending; accepts a command while under the outstanding limit
//  ISSUE | AW and/or W beat of the last accepted command still awaiting its handshake
module axil_wr_cmd_master #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int STRB_WIDTH      = DATA_WIDTH/8,
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING+1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [2:0]            cmd_prot,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   input  logic [STRB_WIDTH-1:0] cmd_strb,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   output logic [1:0]            resp_bresp,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
   output logic [2:0]            m_axil_awprot,
   output logic                  m_axil_awvalid,
   input  logic                  m_axil_awready,
   output logic [DATA_WIDTH-1:0] m_axil_wdata,
   output logic [STRB_WIDTH-1:0] m_axil_wstrb,
   output logic                  m_axil_wvalid,
   input  logic                  m_axil_wready,
   input  logic [1:0]            m_axil_bresp,
   input  logic                  m_axil_bvalid,
   output logic                  m_axil_bready,
   output logic [CNT_WIDTH-1:0]  outstanding,
   output logic                  busy,
   output logic [15:0]           err_count
);

   typedef enum logic {IDLE, ISSUE} state_t;

   localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

   state_t      state, state_nxt;
   logic        cmd_fire, aw_fire, w_fire, b_fire;
   logic [15:0] err_cnt_q;

   // Ready signals depend only on registered state, never on same-cycle valids.
   assign cmd_ready     = (state == IDLE) && (outstanding < MAX_CNT);
   assign m_axil_bready = !resp_valid && (outstanding != '0);
   assign cmd_fire      = cmd_valid && cmd_ready;
   assign aw_fire       = m_axil_awvalid && m_axil_awready;
   assign w_fire        = m_axil_wvalid && m_axil_wready;
   assign b_fire        = m_axil_bvalid && m_axil_bready;
   assign busy          = (outstanding != '0) || m_axil_awvalid || m_axil_wvalid || resp_valid;
   assign err_count     = err_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (cmd_fire) state_nxt = ISSUE;
         ISSUE: if ((aw_fire || !m_axil_awvalid) && (w_fire || !m_axil_wvalid)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_axil_awaddr  <= '0;
         m_axil_awprot  <= '0;
         m_axil_awvalid <= 1'b0;
         m_axil_wdata   <= '0;
         m_axil_wstrb   <= '0;
         m_axil_wvalid  <= 1'b0;
      end else begin
         if (cmd_fire) begin
            m_axil_awaddr  <= cmd_addr;
            m_axil_awprot  <= cmd_prot;
            m_axil_wdata   <= cmd_data;
            m_axil_wstrb   <= cmd_strb;
            m_axil_awvalid <= 1'b1;
            m_axil_wvalid  <= 1'b1;
         end else begin
            if (aw_fire) m_axil_awvalid <= 1'b0;
            if (w_fire)  m_axil_wvalid  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding <= '0;
         resp_valid  <= 1'b0;
         resp_bresp  <= 2'b00;
         err_cnt_q   <= '0;
      end else begin
         case ({cmd_fire, b_fire})
            2'b10:   outstanding <= outstanding + CNT_WIDTH'(1);
            2'b01:   outstanding <= outstanding - CNT_WIDTH'(1);
            default: outstanding <= outstanding;
         endcase
         // bready is low while a response is held, so set and clear never collide.
         if (b_fire) begin
            resp_valid <= 1'b1;
            resp_bresp <= m_axil_bresp;
            if (m_axil_bresp != 2'b00 && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
         end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
         end
      end
   end

endmodule
